// File: rtl/apb_regs_bridge.sv
// ---------------------------------------------------------------------------
// apb_regs_bridge
//
// APB4 slave front end for small peripheral register banks. Each APB transfer
// is registered at its setup phase, checked for range and alignment, and
// turned into a single-cycle read or write strobe on the internal register
// bus. The register side finishes the access with reg_ready (and may flag
// reg_err). The APB response (pready/pslverr/prdata) is driven from flops.
//
// Handshake semantics (one place, applies to the whole block):
//   APB side : a setup phase (psel=1, penable=0) is only accepted in IDLE.
//              The transfer completes in the single cycle pready=1; pslverr
//              and prdata are meaningful only in that cycle. psel=0 in any
//              later phase abandons the transfer and no response is issued.
//   Reg side : reg_wr_en/reg_rd_en pulse for exactly one cycle per accepted
//              transfer. The request stays outstanding (reg_addr, reg_wdata,
//              reg_wstrb stable) until reg_ready=1 is seen in the strobe
//              cycle or a later WAIT cycle; reg_rdata/reg_err are sampled
//              only together with that reg_ready.
//
// Parameters:
//   ADDR_WD     address width in bits
//   DATA_WD     data width (8, 16 or 32); strobe width is DATA_WD/8
//   REG_SPAN    implemented bytes; paddr >= REG_SPAN gives pslverr
//   TIMEOUT_CYC WAIT-state limit, used only with APB_REGS_TIMEOUT_EN
//
// Optional build macro:
//   APB_REGS_TIMEOUT_EN  when defined, a WAIT that lasts TIMEOUT_CYC cycles
//                        without reg_ready ends with pslverr=1.
//
// Ports:
//   pclk, preset                 clock, synchronous active-high reset
//   psel, penable, pwrite,       APB request
//   paddr, pwdata, pstrb
//   prdata, pready, pslverr      APB response (registered)
//   reg_addr, reg_wdata,         internal bus request, latched at setup
//   reg_wstrb                    (reg_wstrb is 0 for reads)
//   reg_wr_en, reg_rd_en         one-cycle access strobes
//   reg_rdata, reg_ready,        internal bus completion
//   reg_err
//   dbg_state_o                  current FSM state, for observation only
// ---------------------------------------------------------------------------
module apb_regs_bridge #(
  parameter int ADDR_WD     = 12,
  parameter int DATA_WD     = 32,
  parameter int REG_SPAN    = 256,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [ADDR_WD-1:0]     paddr,
  input  logic [DATA_WD-1:0]     pwdata,
  input  logic [DATA_WD/8-1:0]   pstrb,
  output logic [DATA_WD-1:0]     prdata,
  output logic                   pready,
  output logic                   pslverr,
  output logic [ADDR_WD-1:0]     reg_addr,
  output logic                   reg_wr_en,
  output logic                   reg_rd_en,
  output logic [DATA_WD-1:0]     reg_wdata,
  output logic [DATA_WD/8-1:0]   reg_wstrb,
  input  logic [DATA_WD-1:0]     reg_rdata,
  input  logic                   reg_ready,
  input  logic                   reg_err,
  output logic [1:0]             dbg_state_o
);

  localparam int STRB_WD = DATA_WD / 8;

  // One extra bit so a REG_SPAN equal to 2**ADDR_WD still compares correctly.
  localparam logic [ADDR_WD:0]   SPAN       = (ADDR_WD+1)'(REG_SPAN);
  // Low address bits that must be zero for a word-aligned access; all-zero
  // mask when DATA_WD is 8, so every byte address is aligned.
  localparam logic [ADDR_WD-1:0] ALIGN_MASK = ADDR_WD'(STRB_WD - 1);

  if (!(DATA_WD == 8 || DATA_WD == 16 || DATA_WD == 32) || TIMEOUT_CYC < 1)
  begin : g_cfg_check
    $error("apb_regs_bridge: unsupported DATA_WD or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 write_q, write_d;
  logic [ADDR_WD-1:0]   addr_q, addr_d;
  logic [DATA_WD-1:0]   wdata_q, wdata_d;
  logic [STRB_WD-1:0]   wstrb_q, wstrb_d;
  logic                 wr_en_q, wr_en_d;
  logic                 rd_en_q, rd_en_d;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATA_WD-1:0]   prdata_q, prdata_d;

`ifdef APB_REGS_TIMEOUT_EN
  localparam int                CNT_WD   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(TIMEOUT_CYC - 1);
  logic [CNT_WD-1:0]            cnt_q, cnt_d;
`endif

  logic                 setup_bad;
  logic [DATA_WD-1:0]   done_rdata;

  assign setup_bad  = ({1'b0, paddr} >= SPAN) || ((paddr & ALIGN_MASK) != '0);
  // Read data is only returned for a read the register side accepted cleanly.
  assign done_rdata = (write_q || reg_err) ? '0 : reg_rdata;

  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = '0;
`ifdef APB_REGS_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          write_d = pwrite;
          addr_d  = paddr;
          wdata_d = pwdata;
          wstrb_d = pwrite ? pstrb : '0;
          if (setup_bad) begin
            // Rejected without touching the register bus.
            state_d   = S_RESP;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d = S_REQ;
            wr_en_d = pwrite;
            rd_en_d = !pwrite;
          end
        end
      end

      S_REQ: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (reg_ready) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = reg_err;
          prdata_d  = done_rdata;
        end else begin
          state_d = S_WAIT;
`ifdef APB_REGS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
        end else if (reg_ready) begin
          // A completion in the final timeout cycle still wins.
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = reg_err;
          prdata_d  = done_rdata;
`ifdef APB_REGS_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_RESP;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= S_IDLE;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
`ifdef APB_REGS_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
`ifdef APB_REGS_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign reg_addr    = addr_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_rd_en   = rd_en_q;
  assign reg_wdata   = wdata_q;
  assign reg_wstrb   = wstrb_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_apb_regs_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_regs_bridge
//
// Drives APB transfers into apb_regs_bridge while acting as the register
// side. Expected responses come from a transaction-level model: a transfer
// is bad when it is out of range or misaligned, a good transfer issues one
// strobe and completes n_wait+2 cycles after its setup cycle, and the
// response carries the register-side data/error. Timing points: inputs are
// driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_apb_regs_bridge;

  localparam int ADDR_WD     = 12;
  localparam int DATA_WD     = 32;
  localparam int STRB_WD     = DATA_WD / 8;
  localparam int REG_SPAN    = 256;
  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_CYC     = 200;

`ifdef APB_REGS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic                 pclk = 1'b0;
  logic                 preset;
  logic                 psel, penable, pwrite;
  logic [ADDR_WD-1:0]   paddr;
  logic [DATA_WD-1:0]   pwdata;
  logic [STRB_WD-1:0]   pstrb;
  logic [DATA_WD-1:0]   prdata;
  logic                 pready, pslverr;
  logic [ADDR_WD-1:0]   reg_addr;
  logic                 reg_wr_en, reg_rd_en;
  logic [DATA_WD-1:0]   reg_wdata;
  logic [STRB_WD-1:0]   reg_wstrb;
  logic [DATA_WD-1:0]   reg_rdata;
  logic                 reg_ready, reg_err;
  logic [1:0]           dbg_state;

  int cyc = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb_regs_bridge #(
    .ADDR_WD    (ADDR_WD),
    .DATA_WD    (DATA_WD),
    .REG_SPAN   (REG_SPAN),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .pclk       (pclk),
    .preset     (preset),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .paddr      (paddr),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr),
    .reg_addr   (reg_addr),
    .reg_wr_en  (reg_wr_en),
    .reg_rd_en  (reg_rd_en),
    .reg_wdata  (reg_wdata),
    .reg_wstrb  (reg_wstrb),
    .reg_rdata  (reg_rdata),
    .reg_ready  (reg_ready),
    .reg_err    (reg_err),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [DATA_WD:0] exp_q[$];   // {pslverr, prdata} per transfer, in order

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prdata"},  prdata,    0);
    check({tag, "_pready"},  pready,    0);
    check({tag, "_pslverr"}, pslverr,   0);
    check({tag, "_addr"},    reg_addr,  0);
    check({tag, "_wr_en"},   reg_wr_en, 0);
    check({tag, "_rd_en"},   reg_rd_en, 0);
    check({tag, "_wdata"},   reg_wdata, 0);
    check({tag, "_wstrb"},   reg_wstrb, 0);
  endtask

  // ---------------- reference model ----------------
  function automatic bit addr_bad(input logic [ADDR_WD-1:0] a);
    return (int'(a) >= REG_SPAN) || ((int'(a) % STRB_WD) != 0);
  endfunction

  // ---------------- driver tasks ----------------
  // Full transfer starting in an IDLE cycle. n_wait = WAIT cycles before the
  // register side answers. Returns in the IDLE cycle after the response.
  task automatic apb_xfer(input bit wr, input logic [ADDR_WD-1:0] addr,
                          input logic [DATA_WD-1:0] data, input logic [STRB_WD-1:0] strb,
                          input int n_wait, input logic [DATA_WD-1:0] rdata, input bit err);
    bit               bad, timed_out, done, exp_err;
    int               k, n_strb, lat, exp_lat;
    logic [DATA_WD:0] got, exp;

    bad       = addr_bad(addr);
    timed_out = TO_EN && !bad && (n_wait > TIMEOUT_CYC);
    exp_lat   = bad ? 1 : (timed_out ? TIMEOUT_CYC + 2 : n_wait + 2);
    exp_err   = bad || timed_out || err;
    exp_q.push_back({exp_err, (!wr && !exp_err) ? rdata : {DATA_WD{1'b0}}});

    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = addr; pwdata = data; pstrb = strb; reg_ready = 1'b0;
    k = 0; done = 1'b0; n_strb = 0; lat = 0; got = '0;
    while (!done && k < MAX_CYC) begin
      tick();
      k++;
      if (reg_wr_en || reg_rd_en) begin
        n_strb++;
        check("strobe_cycle", k, 1);
        check("strobe_kind", {reg_wr_en, reg_rd_en}, wr ? 2'b10 : 2'b01);
        check("reg_wstrb", reg_wstrb, wr ? strb : '0);
        check("reg_wdata", reg_wdata, data);
      end
      check("reg_addr", reg_addr, addr);
      if (pready) begin
        done = 1'b1;
        lat  = k;
        got  = {pslverr, prdata};
      end else begin
        penable   = 1'b1;
        reg_ready = (k == n_wait + 1);
        reg_rdata = reg_ready ? rdata : $urandom();
        reg_err   = reg_ready ? err : 1'($urandom_range(0, 1));
      end
    end
    check("pready_within_bound", done, 1);
    exp = exp_q.pop_front();
    if (!done) begin
      psel = 1'b0; penable = 1'b0; reg_ready = 1'b0;
      tick(); tick();
    end else begin
      check("latency", lat, exp_lat);
      check("pslverr", got[DATA_WD], exp[DATA_WD]);
      check("prdata", got[DATA_WD-1:0], exp[DATA_WD-1:0]);
      check("strobe_count", n_strb, bad ? 0 : 1);
      // Register-side activity during RESP must be ignored.
      reg_ready = 1'($urandom_range(0, 1));
      reg_err   = 1'($urandom_range(0, 1));
      reg_rdata = $urandom();
      tick();
      reg_ready = 1'b0;
      check("post_pready", pready, 0);
      check("post_pslverr", pslverr, 0);
      check("post_prdata", prdata, 0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      psel = 1'b0; penable = 1'b0;
      reg_ready = 1'($urandom_range(0, 1));
      reg_err   = 1'($urandom_range(0, 1));
      reg_rdata = $urandom();
      tick();
      check("idle_quiet", {pready, reg_wr_en, reg_rd_en}, 3'b000);
    end
    reg_ready = 1'b0;
  endtask

  // Start a good read and drop psel at access cycle drop_k (1 = REQ).
  task automatic apb_abort(input logic [ADDR_WD-1:0] addr, input int drop_k);
    int n_strb, n_rdy;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr; reg_ready = 1'b0;
    n_strb = 0; n_rdy = 0;
    for (int k = 1; k <= drop_k + 5; k++) begin
      tick();
      n_strb += int'(reg_wr_en) + int'(reg_rd_en);
      n_rdy  += int'(pready);
      penable = (k < drop_k);
      psel    = (k < drop_k);
    end
    check("abort_strobes", n_strb, 1);
    check("abort_no_pready", n_rdy, 0);
  endtask

  task automatic reset_in_wait();
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h040; reg_ready = 1'b0;
    repeat (3) begin
      tick();
      penable = 1'b1;
    end
    preset = 1'b1; psel = 1'b0; penable = 1'b0;
    tick();
    check_all_zero("rst_wait");
    preset = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int c0;

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    reg_rdata = '0; reg_ready = 1'b0; reg_err = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    preset = 1'b0;
    tick();

    // Directed cases.
    apb_xfer(1'b1, 12'h010, 32'hA5A5_1234, 4'b0011, 0, 32'h0, 1'b0);
    idle(1);
    apb_xfer(1'b0, 12'h020, 32'h0, 4'b1111, 3, 32'hDEAD_BEEF, 1'b0);
    idle(1);
    apb_xfer(1'b0, 12'h100, 32'h0, 4'b0000, 0, 32'h1234_5678, 1'b0);
    apb_xfer(1'b1, 12'h006, 32'hCAFE_F00D, 4'b1111, 0, 32'h0, 1'b0);
    apb_xfer(1'b0, 12'h0FC, 32'h0, 4'b0000, 1, 32'h0BAD_F00D, 1'b1);
    apb_xfer(1'b0, 12'h0FF, 32'h0, 4'b0000, 0, 32'h0, 1'b0);
    idle(2);

    // Four back-to-back writes: three cycles each, no idle cycle between.
    c0 = cyc;
    for (int i = 0; i < 4; i++)
      apb_xfer(1'b1, 12'(16 * i), $urandom(), 4'(i + 1), 0, 32'h0, 1'b0);
    check("b2b_cycles", cyc - c0, 12);

    reset_in_wait();
    apb_xfer(1'b0, 12'h044, 32'h0, 4'b0000, 1, 32'h1357_9BDF, 1'b0);

    apb_abort(12'h080, 1);
    apb_abort(12'h084, 3);
    apb_xfer(1'b1, 12'h088, 32'h0F0F_0F0F, 4'b1000, 2, 32'h0, 1'b0);

`ifdef APB_REGS_TIMEOUT_EN
    apb_xfer(1'b0, 12'h08C, 32'h0, 4'b0000, 40, 32'h2468_ACE0, 1'b0);
    apb_xfer(1'b0, 12'h090, 32'h0, 4'b0000, TIMEOUT_CYC, 32'h1111_2222, 1'b0);
`else
    begin : no_timeout
      int n_rdy;
      n_rdy = 0;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h08C; reg_ready = 1'b0;
      for (int k = 0; k < 100; k++) begin
        tick();
        penable = 1'b1;
        n_rdy += int'(pready);
      end
      check("no_timeout_pready", n_rdy, 0);
      psel = 1'b0; penable = 1'b0;
      tick(); tick();
    end
`endif

    // Randomized transfers.
    for (int i = 0; i < 60; i++) begin
      logic [ADDR_WD-1:0] a;
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = 12'($urandom_range(REG_SPAN, 4095));
      else if (sel == 1) a = 12'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else               a = 12'($urandom_range(0, 63) * 4);
      apb_xfer(1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)),
               $urandom_range(0, 4), $urandom(), ($urandom_range(0, 7) == 0));
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
